// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time instruction-memory writer.
// Receives a length-prefixed byte stream (LEN0, LEN1, N*4 data bytes LSB-first),
// assembles 32-bit words and writes them sequentially from BASE_ADDR, holding the
// core until the image has been accepted.
// Optional feature macro: CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
module imem_boot_loader #(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
`ifdef CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    // State entered once the payload is complete (or empty).
`ifdef CHECKSUM_EN
    localparam state_e S_TAIL = S_CSUM;
`else
    localparam state_e S_TAIL = S_DONE;
`endif

    localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;       // N, word count of the image
    logic [1:0]        bidx_q, bidx_d;     // byte position inside current word
    logic [31:0]       word_q, word_d;     // word under assembly
    logic [15:0]       widx_q, widx_d;     // index of next word to write
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       wl_q, wl_d;
`ifdef CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;     // running XOR of LEN0, LEN1 and data
`endif

    logic        fire;
    logic [15:0] len_n;
    logic [31:0] word_asm;
    logic [15:0] widx_inc;

    // Byte acceptance is a pure function of the registered state.
    always_comb begin
        rx_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
`ifdef CHECKSUM_EN
        if (state_q == S_CSUM) rx_ready = 1'b1;
`endif
    end

    // Status outputs decode the registered state, so they change exactly at state entry.
    always_comb begin
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERR);
        core_hold = (state_q != S_DONE);
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = wl_q;

    // Next-state and datapath update for the frame parser.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wl_d    = wl_q;
`ifdef CHECKSUM_EN
        csum_d  = csum_q;
`endif
        fire     = rx_valid && rx_ready;
        len_n    = {rx_data, len_q[7:0]};
        word_asm = word_q;
        word_asm[{bidx_q, 3'b000} +: 8] = rx_data;
        widx_inc = widx_q + 16'd1;

        case (state_q)
            // start is only honoured when no frame is in flight.
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN0;
                    len_d   = '0;
                    bidx_d  = '0;
                    word_d  = '0;
                    widx_d  = '0;
                    addr_d  = BASE_ADDR;
                    wl_d    = '0;
`ifdef CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN0: begin
                if (fire) begin
                    len_d[7:0] = rx_data;
`ifdef CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (fire) begin
                    len_d[15:8] = rx_data;
`ifdef CHECKSUM_EN
                    csum_d      = csum_q ^ rx_data;
`endif
                    // Oversize rejected before any write, so the word index stays in range.
                    if (len_n > DEPTH_N)      state_d = S_ERR;
                    else if (len_n == 16'd0)  state_d = S_TAIL;
                    else                      state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fire) begin
                    word_d = word_asm;
                    bidx_d = bidx_q + 2'd1;
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word_asm;
                        addr_d  = BASE_ADDR + ADDR_W'({widx_q, 2'b00});
                        wl_d    = widx_inc;
                        widx_d  = widx_inc;
                        if (widx_inc == len_q) state_d = S_TAIL;
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (fire) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any partial load immediately.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wl_q    <= '0;
`ifdef CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wl_q    <= wl_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of frames plus hand-written corner sequences.
// Expected memory writes go into a scoreboard queue as frames are driven and are
// compared when the loader pulses imem_we.
module tb_imem_boot_loader;

    localparam int ADDR_W = 32;
`ifdef CHECKSUM_EN
    localparam int CSB = 1;
`else
    localparam int CSB = 0;
`endif

    logic              clk;
    logic              areset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(64), .BASE_ADDR('0)) dut (
        .clk(clk), .areset(areset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q [$];   // {addr, data} of writes still owed by the DUT

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard consumer: each write strobe must match the oldest owed write.
    always @(negedge clk) begin
        if (areset && imem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e[63:32]));
                chk("wr_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        int               nb;
        logic [0:11][7:0] b;
        bit               gaps;
        bit               mstart;
        bit               exp_done;
        bit               exp_err;
        int               exp_wl;
        int               nw;
        logic [0:1][31:0] w;
    } vec_t;

    vec_t vtab [6];

    // Offer one byte (entered and left on a falling edge); bounded wait for rx_ready.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            n_checks++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_st_hold"}, 64'(core_hold), 64'd1);
        chk({tag, "_st_done"}, 64'(done), 64'd0);
        chk({tag, "_st_err"}, 64'(error), 64'd0);
        chk({tag, "_st_wl"}, 64'(words_loaded), 64'd0);
        chk({tag, "_st_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_st_rdy"}, 64'(rx_ready), 64'd1);
    endtask

    task automatic check_end(input string tag, input bit d, input bit e, input int wl);
        repeat (2) @(negedge clk);
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'(d));
        chk({tag, "_err"}, 64'(error), 64'(e));
        chk({tag, "_hold"}, 64'(core_hold), 64'(!d));
        chk({tag, "_wl"}, 64'(words_loaded), 64'(wl));
        chk({tag, "_rdy"}, 64'(rx_ready), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        string tag;
        v   = vtab[i];
        tag = $sformatf("vec%0d", i);
        pulse_start(tag);
        for (int k = 0; k < v.nw; k++) exp_q.push_back({32'(4 * k), v.w[k]});
        for (int k = 0; k < v.nb; k++) begin
            if (v.gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    start = v.mstart;   // mid-frame start must be ignored
                    @(negedge clk);
                end
                start = 1'b0;
            end
            send_byte(v.b[k]);
        end
        check_end(tag, v.exp_done, v.exp_err, v.exp_wl);
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] wd;

        vtab[0] = '{nb: 10 + CSB,
                    b: {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00, 8'h72, 8'h00},
                    gaps: 0, mstart: 0, exp_done: 1, exp_err: 0, exp_wl: 2, nw: 2,
                    w: {32'h00A00513, 32'h00500593}};
`ifdef CHECKSUM_EN
        vtab[1] = '{nb: 11,
                    b: {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00},
                    gaps: 0, mstart: 0, exp_done: 0, exp_err: 1, exp_wl: 2, nw: 2,
                    w: {32'h00A00513, 32'h00500593}};
`else
        vtab[1] = '{nb: 6,
                    b: {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    gaps: 0, mstart: 0, exp_done: 1, exp_err: 0, exp_wl: 1, nw: 1,
                    w: {32'hDEADBEEF, 32'h0}};
`endif
        vtab[2] = '{nb: 2, b: {8'h41, 8'h00, 80'h0},
                    gaps: 0, mstart: 0, exp_done: 0, exp_err: 1, exp_wl: 0, nw: 0, w: '0};
        vtab[3] = '{nb: 2 + CSB, b: {8'h00, 8'h00, 8'h00, 72'h0},
                    gaps: 0, mstart: 0, exp_done: 1, exp_err: 0, exp_wl: 0, nw: 0, w: '0};
        vtab[4] = vtab[0];
        vtab[4].gaps   = 1;
        vtab[4].mstart = 1;
        vtab[5] = '{nb: 2, b: {8'h00, 8'h01, 80'h0},
                    gaps: 0, mstart: 0, exp_done: 0, exp_err: 1, exp_wl: 0, nw: 0, w: '0};

        areset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 64'(rx_ready), 64'd0);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_hold", 64'(core_hold), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        chk("rst_wl", 64'(words_loaded), 64'd0);
        areset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_rdy", 64'(rx_ready), 64'd0);
        chk("idle_hold", 64'(core_hold), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // From DONE: start and a byte in the same cycle; the byte must not be taken.
        run_vec(0);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
        #1 chk("stbyte_rdy", 64'(rx_ready), 64'd0);
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        if (CSB == 1) send_byte(8'h00);
        check_end("stbyte", 1'b1, 1'b0, 0);

        // Reset in the middle of DATA after one word has been written.
        pulse_start("rstmid");
        exp_q.push_back({32'h0, 32'h00A00513});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'h93);
        chk("rstmid_wl_before", 64'(words_loaded), 64'd1);
        #2 areset = 1'b0;
        #1;
        chk("rstmid_rdy", 64'(rx_ready), 64'd0);
        chk("rstmid_wdata", 64'(imem_wdata), 64'd0);
        chk("rstmid_wl", 64'(words_loaded), 64'd0);
        chk("rstmid_hold", 64'(core_hold), 64'd1);
        chk("rstmid_we", 64'(imem_we), 64'd0);
        chk("rstmid_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        run_vec(0);
        run_vec(1);   // restart from DONE, overwriting from the base address

        // Largest accepted image: exactly 64 words.
        pulse_start("max");
        cs = 8'h40;
        send_byte(8'h40);
        send_byte(8'h00);
        for (int k = 0; k < 64; k++) begin
            logic [7:0] kk;
            kk = 8'(k);
            wd = {kk, ~kk, kk + 8'h11, 8'h3C};
            exp_q.push_back({32'(4 * k), wd});
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ wd[8*j +: 8];
                send_byte(wd[8*j +: 8]);
            end
        end
        if (CSB == 1) send_byte(cs);
        check_end("max", 1'b1, 1'b0, 64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
